mem_access_unit: RTL

- Load/store initiator on the CPU side of the data RAM.
- Accepts byte, halfword and word requests from the datapath through a valid/ready handshake.
- Word-aligns each access and drives the RAM's `addr`/`write_data`/`memread`/`memwrite` port.
- Performs sub-word stores as read-modify-write and returns sign- or zero-extended load data.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit_lane_mux.sv | 58 +++++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM state type and the access-legality check for the
// load/store unit on the CPU side of the data RAM.
package mem_access_unit_pkg;

  localparam int unsigned WORDSIZE    = 32;
  localparam int unsigned ROM_COL_MAX = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_RD   = 2'b01,
    LSU_WR   = 2'b10,
    LSU_RESP = 2'b11
  } lsu_state_e;

  // The range test runs in 33 bits so a word near 4 GiB cannot wrap past the check.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned mem_bytes);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr[31:2], 2'b00} + 33'd4;
    return ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
           (size == 2'b11) ||
           (end_addr > {1'b0, mem_bytes});
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath request/response handshake plus the RAM port, bundled as one bus.
// master = datapath/RAM side, slave = mem_access_unit.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [31:0]         req_addr;
  logic [WORDSIZE-1:0] req_wdata;

  logic                resp_valid;
  logic                resp_ready;
  logic [WORDSIZE-1:0] resp_rdata;
  logic                resp_err;

  logic [31:0]         mem_addr;
  logic [WORDSIZE-1:0] mem_wdata;
  logic                mem_read;
  logic                mem_write;
  logic [WORDSIZE-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/mem_access_unit_lane_mux.sv
// Big-endian lane select: extracts and extends load lanes, and merges store
// lanes into a previously read word. Purely combinational.
module mem_access_unit_lane_mux
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]          size,
  input  logic [1:0]          offset,
  input  logic                is_unsigned,
  input  logic [WORDSIZE-1:0] rdata,
  input  logic [WORDSIZE-1:0] wdata,
  output logic [WORDSIZE-1:0] load_val,
  output logic [WORDSIZE-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    lane_b = rdata[7:0];
    unique case (offset)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    load_val = rdata;
    merged   = wdata;
    unique case (size)
      SZ_BYTE: begin
        load_val = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        merged   = rdata;
        unique case (offset)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_val = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        merged   = rdata;
        if (offset[1]) merged[15:0]  = wdata[15:0];
        else           merged[31:16] = wdata[15:0];
      end
      default: begin
        load_val = rdata;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one outstanding access, word-aligned RAM port,
// sub-word stores done as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = ROM_COL_MAX
) (
  input  logic             CLK,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  lsu_state_e          state;
  logic                r_write;
  logic                r_unsigned;
  logic [1:0]          r_size;
  logic [1:0]          r_offset;
  logic [WORDSIZE-1:0] r_wdata;

  logic                resp_valid_q;
  logic                resp_err_q;
  logic [WORDSIZE-1:0] resp_rdata_q;
  logic [31:0]         mem_addr_q;
  logic [WORDSIZE-1:0] mem_wdata_q;
  logic                mem_read_q;
  logic                mem_write_q;

  logic                req_fire;
  logic                req_err;
  logic [WORDSIZE-1:0] load_val;
  logic [WORDSIZE-1:0] merged;

  assign bus.req_ready  = (state == LSU_IDLE) & reset;
  assign req_fire       = bus.req_valid & bus.req_ready;
  assign req_err        = access_error(bus.req_size, bus.req_addr, MEM_BYTES);

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;

  // RAM data is combinational on mem_addr, so during RD the lane mux sees the live word.
  mem_access_unit_lane_mux u_lane_mux (
    .size        (r_size),
    .offset      (r_offset),
    .is_unsigned (r_unsigned),
    .rdata       (bus.mem_rdata),
    .wdata       (r_wdata),
    .load_val    (load_val),
    .merged      (merged)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state        <= LSU_IDLE;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SZ_BYTE;
      r_offset     <= 2'b00;
      r_wdata      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      unique case (state)
        LSU_IDLE: begin
          if (req_fire) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_offset   <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            if (req_err) begin
              state        <= LSU_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              state       <= LSU_WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state      <= LSU_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LSU_RD: begin
          mem_read_q <= 1'b0;
          if (r_write) begin
            state       <= LSU_WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            state        <= LSU_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val;
          end
        end
        LSU_WR: begin
          state        <= LSU_RESP;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        LSU_RESP: begin
          if (bus.resp_ready) begin
            state        <= LSU_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
